// File: rtl/arith_pkg.sv
// Shared arithmetic-library package: divider FSM states, default operand
// width and the bit-counter width helper.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Bits needed to hold a count of w-1 down to 0 (never less than 1).
    function automatic int cnt_width(input int w);
        return ($clog2(w) > 0) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/add_sub_unit.sv
// Parameterised ripple-carry add/subtract. m_i=1 subtracts by inverting b_i
// and injecting a carry-in of 1. For subtraction, borrow = ~cout_o.
module add_sub_unit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         m_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    logic [N:0]   carry;
    logic [N-1:0] b_x;

    // Ripple the carry bit by bit through the full-adder chain.
    always_comb begin
        b_x      = b_i ^ {N{m_i}};
        carry    = '0;
        carry[0] = m_i;
        s_o      = '0;
        for (int k = 0; k < N; k++) begin
            s_o[k]     = a_i[k] ^ b_x[k] ^ carry[k];
            carry[k+1] = (a_i[k] & b_x[k]) | (carry[k] & (a_i[k] ^ b_x[k]));
        end
    end

    assign cout_o = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// start/busy/done handshake: start is sampled only while busy=0 (IDLE or
// DONE); busy is high for the WIDTH trial-subtraction cycles; done pulses for
// one cycle when quotient/remainder/div_by_zero are updated, and they hold
// until the next completion. state_o exposes the FSM state for debug.
// Optional build macro SEQ_DIVIDER_SIGNED_EN selects two's-complement
// operands (magnitudes divided, signs applied at capture and completion).
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       state_o
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Trial subtraction on WIDTH+1 bits so the shifted-out MSB of R is kept.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_cout;
    logic             no_borrow;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

    assign shifted = {r_q, q_q[WIDTH-1]};

    add_sub_unit #(.N(WIDTH + 1)) u_trial (
        .a_i    (shifted),
        .b_i    ({1'b0, dvs_q}),
        .m_i    (1'b1),
        .s_o    (trial),
        .cout_o (trial_cout)
    );

    assign no_borrow = trial_cout;
    assign step_r    = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_q    = {q_q[WIDTH-2:0], no_borrow};

    // Operand magnitudes at capture and signed results at completion.
    logic [WIDTH-1:0] mag_dvd;
    logic [WIDTH-1:0] mag_dvs;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;
    logic             unused_bits;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] neg_dvd, neg_dvs, neg_q, neg_r;
    logic             c_dvd, c_dvs, c_q, c_r;

    add_sub_unit #(.N(WIDTH)) u_neg_dvd (
        .a_i('0), .b_i(dividend), .m_i(1'b1), .s_o(neg_dvd), .cout_o(c_dvd));
    add_sub_unit #(.N(WIDTH)) u_neg_dvs (
        .a_i('0), .b_i(divisor), .m_i(1'b1), .s_o(neg_dvs), .cout_o(c_dvs));
    add_sub_unit #(.N(WIDTH)) u_neg_q (
        .a_i('0), .b_i(step_q), .m_i(1'b1), .s_o(neg_q), .cout_o(c_q));
    add_sub_unit #(.N(WIDTH)) u_neg_r (
        .a_i('0), .b_i(step_r), .m_i(1'b1), .s_o(neg_r), .cout_o(c_r));

    assign mag_dvd     = dividend[WIDTH-1] ? neg_dvd : dividend;
    assign mag_dvs     = divisor[WIDTH-1]  ? neg_dvs : divisor;
    assign fin_q       = qneg_q ? neg_q : step_q;
    assign fin_r       = rneg_q ? neg_r : step_r;
    assign unused_bits = ^{trial[WIDTH], c_dvd, c_dvs, c_q, c_r};

    // Sign flags for the operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end
`else
    assign mag_dvd     = dividend;
    assign mag_dvs     = divisor;
    assign fin_q       = step_q;
    assign fin_r       = step_r;
    assign unused_bits = trial[WIDTH];
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic: accept in IDLE/DONE, shift-subtract in RUN.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        // No RUN cycles: results are known immediately.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = '0;
                        q_d     = mag_dvd;
                        dvs_d   = mag_dvs;
                        cnt_d   = CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rneg_d  = dividend[WIDTH-1];
`endif
                    end
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = fin_q;
                    rem_d   = fin_r;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (unsigned build, WIDTH=4).
// Expected {div_by_zero, remainder, quotient} words are queued when a start
// is accepted and compared when done is seen.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   state_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [2*W:0] exp_q[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .state_o     (state_o)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: {div_by_zero, remainder, quotient}.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] qq;
        logic [W-1:0] rr;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        qq = a / b;
        rr = a % b;
        return {1'b0, rr, qq};
    endfunction

    // Scoreboard: every done pops one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got q=%0d r=%0d dbz=%0b with nothing outstanding",
                         quotient, remainder, div_by_zero);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                if ({div_by_zero, remainder, quotient} !== e) begin
                    miscompares++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0b, expected q=%0d r=%0d dbz=%0b",
                             quotient, remainder, div_by_zero, e[W-1:0], e[2*W-1:W], e[2*W]);
                end
            end
        end
    end

    // Driver: call just after a negedge while busy=0; returns #1 after accept.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count busy cycles after the accept edge and find the done cycle.
    task automatic observe(output int busy_cycles, output int done_at);
        busy_cycles = 0;
        done_at = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_at = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        vectors++;
        if (state_o !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d expected 0", state_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bc, da;
        @(negedge clk);
        issue(4'd13, 4'd3);
        observe(bc, da);
        vectors++;
        if (da !== 5) begin
            miscompares++;
            $display("FAIL basic_latency: done at %0d expected 5", da);
        end
        vectors++;
        if (bc !== 4) begin
            miscompares++;
            $display("FAIL basic_busy: busy %0d cycles expected 4", bc);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({done, quotient, remainder} !== {1'b0, 4'd4, 4'd1}) begin
            miscompares++;
            $display("FAIL basic_hold: done=%0b q=%0d r=%0d expected 0/4/1", done, quotient, remainder);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] ta[4];
        logic [W-1:0] tb[4];
        int bc, da;
        ta = '{4'd15, 4'd2, 4'd0, 4'd15};
        tb = '{4'd1, 4'd7, 4'd5, 4'd15};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(ta[i], tb[i]);
            observe(bc, da);
            vectors++;
            if (da !== 5 || bc !== 4) begin
                miscompares++;
                $display("FAIL vector_timing %0d/%0d: done at %0d busy %0d, expected 5 and 4",
                         ta[i], tb[i], da, bc);
            end
        end
    endtask

    task automatic test_div_zero();
        int bc, da;
        @(negedge clk);
        issue(4'd9, 4'd0);
        observe(bc, da);
        vectors++;
        if (da !== 1 || bc !== 0) begin
            miscompares++;
            $display("FAIL div_zero_timing: done at %0d busy %0d, expected 1 and 0", da, bc);
        end
    endtask

    task automatic test_busy_ignore();
        int dones, first;
        dones = 0;
        first = -1;
        @(negedge clk);
        issue(4'd13, 4'd3);
        @(negedge clk);
        @(negedge clk);
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 4; k < 16; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (first < 0) first = k;
            end
        end
        vectors++;
        if (dones !== 1 || first !== 5) begin
            miscompares++;
            $display("FAIL busy_ignore: %0d dones first at %0d, expected 1 done at 5", dones, first);
        end
    endtask

    task automatic test_reset_mid_run();
        int bc, da;
        @(negedge clk);
        issue(4'd13, 4'd3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            miscompares++;
            $display("FAIL mid_run_reset: busy=%0b done=%0b q=%0d r=%0d dbz=%0b, expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        exp_q.delete();
        repeat (8) @(negedge clk);
        issue(4'd12, 4'd5);
        observe(bc, da);
        vectors++;
        if (da !== 5) begin
            miscompares++;
            $display("FAIL after_reset_latency: done at %0d expected 5", da);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, prev_b;
        int last_acc, waited;
        prev_b = '0;
        last_acc = -1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a = W'($urandom_range(15, 0));
            b = (i == 3) ? 4'd0 : W'($urandom_range(15, 1));
            waited = 0;
            while (busy && waited < 40) begin
                dividend = W'($urandom_range(15, 0));
                divisor  = W'($urandom_range(15, 0));
                @(negedge clk);
                waited++;
            end
            if (waited >= 40) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_wait: busy stuck high, got busy=%0b expected 0", busy);
                break;
            end
            dividend = a;
            divisor  = b;
            start    = 1'b1;
            exp_q.push_back(model(a, b));
            if (last_acc >= 0) begin
                vectors++;
                if (cyc - last_acc !== ((prev_b == 0) ? 1 : W + 1)) begin
                    miscompares++;
                    $display("FAIL b2b_interval: %0d cycles expected %0d",
                             cyc - last_acc, (prev_b == 0) ? 1 : W + 1);
                end
            end
            last_acc = cyc;
            prev_b = b;
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        int bc, da;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom_range(15, 0));
            b = ($urandom_range(5, 0) == 0) ? 4'd0 : W'($urandom_range(15, 1));
            @(negedge clk);
            issue(a, b);
            observe(bc, da);
            vectors++;
            if (da !== ((b == 0) ? 1 : W + 1)) begin
                miscompares++;
                $display("FAIL random_latency %0d/%0d: done at %0d expected %0d",
                         a, b, da, (b == 0) ? 1 : W + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_busy_ignore();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL outstanding: %0d results never produced, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
